process_scheduler: RTL and testbench
====================================

Name:
process_scheduler

Overview:
- Round-robin, time-sliced process scheduler for the multi-process core.
- Replaces fixed OS/user process switching with NUM_PROC hardware contexts. PID 0 is always the OS.
- Holds a saved-PC table and ready mask. Preempts a user process after QUANTUM retired instructions, or on yield or end_proc.
- Drives PC reload, the register-bank context select and the OS-enable flag.

Parameters:
- NUM_PROC, 4, number of contexts including OS (PID 0); must be ≥2.
- PID_W, 2, PID width; 2^PID_W ≥ NUM_PROC.
- PC_W, 32, program-counter width.
- QUANTUM, 16, retired instructions per time slice; must be ≥1.
- QW, 5, slice-counter width; 2^QW > QUANTUM.

Ports:
- Clock  in  1  system clock, rising edge.
- n_reset  in  1  asynchronous, active-low reset.
- instr_retire  in  1  one-cycle pulse per retired instruction of the running process.
- pc_curr  in  PC_W  PC of the next instruction of the running context.
- end_proc  in  1  running user process terminated.
- yield  in  1  running user process voluntarily gives up the CPU.
- dispatch  in  1  OS requests dispatch of the next ready process.
- proc_create  in  1  OS registers a process as ready.
- create_pid  in  PID_W  PID for proc_create.
- create_pc  in  PC_W  start PC for proc_create.
- cur_pid  out  PID_W  running context; drives register-bank select.
- in_os  out  1  1 while the OS context is active (OS-enable).
- pc_load  out  1  one-cycle pulse: PC must load pc_load_val.
- pc_load_val  out  PC_W  PC to load.
- preempted  out  1  one-cycle pulse when a switch-out was caused by quantum expiry.
- ready_mask  out  NUM_PROC  ready bit per PID; bit 0 is always 0.

Behaviour:
- Reset values (asynchronous, immediate, also mid-operation):
  - state=OS, cur_pid=0, in_os=1, pc_load=0, pc_load_val=0, preempted=0.
  - ready_mask=0, saved PCs=0, slice count=0, rr pointer=NUM_PROC-1.
- States: OS, LOAD, RUN, SAVE.
- OS:
  - On dispatch with ready_mask≠0: saved_pc[0]<=pc_curr. Select the first ready PID searching rr+1, rr+2, … Indices skip 0 and wrap NUM_PROC-1→1. Go to LOAD.
  - dispatch with ready_mask=0: ignored, stay in OS.
  - end_proc, yield and instr_retire are ignored in OS.
- LOAD (1 cycle):
  - pc_load=1, pc_load_val=saved_pc[sel], cur_pid=sel, in_os=0.
  - rr<=sel, slice count<=0. Go to RUN.
  - Dispatch latency is 1 cycle from dispatch to the pc_load pulse.
- RUN:
  - Each instr_retire increments the slice count.
  - Exit triggers, in priority order end_proc > yield > quantum expiry:
    - end_proc: clear ready[cur_pid].
    - yield: ready bit stays set; saved_pc[cur_pid]<=pc_curr.
    - Quantum expiry (instr_retire with count==QUANTUM-1): ready bit stays set; saved_pc[cur_pid]<=pc_curr; preempted asserted in SAVE.
  - Every trigger goes to SAVE.
- SAVE (1 cycle):
  - pc_load=1, pc_load_val=saved_pc[0], cur_pid=0, in_os=1.
  - preempted=1 only if the cause was quantum. Go to OS.
- proc_create (any state):
  - saved_pc[create_pid]<=create_pc, ready[create_pid]<=1.
  - create_pid=0 or ≥NUM_PROC is ignored.
  - A create in the same cycle as a save or end_proc on the same PID wins: the PC comes from create_pc and the ready bit is set.
  - A create while in LOAD does not change the PC already being loaded.
- Outputs are registered. pc_load and preempted are never high outside LOAD/SAVE.
- With a single ready process, round robin re-selects that same process.

Test Plan:
- NUM_PROC=4, QUANTUM=4, reset, create pid1 pc=0x40, then dispatch → next cycle pc_load=1, pc_load_val=0x40, cur_pid=1, in_os=0.
- From that state, 4 instr_retire with pc_curr=0x50 on the last → SAVE: preempted=1, cur_pid=0, in_os=1, pc_load_val=saved OS PC. The next dispatch reloads 0x50.
- Create pids 1,2,3 (pc 0x10,0x20,0x30), then repeated dispatch and yield → dispatch order 1,2,3,1. Each dispatch loads that process's PC. preempted=0 on every switch-out.
- PID 2 running, end_proc and yield asserted together → ready_mask bit2 cleared, preempted=0. A later dispatch never selects 2.
- ready_mask=0, dispatch pulsed → no pc_load, state stays OS, cur_pid=0.
- n_reset low during LOAD → outputs return immediately to reset values and ready_mask=0. create_pid=0 is ignored (ready_mask stays 0).

Source files
------------

// File: rtl/process_scheduler.sv
// Round-robin, time-sliced process scheduler. PID 0 is the OS context;
// user contexts 1..NUM_PROC-1 are dispatched in round-robin order and
// preempted after QUANTUM retired instructions, on yield, or on end_proc.
module process_scheduler #(
  parameter int unsigned NUM_PROC = 4,
  parameter int unsigned PID_W    = 2,
  parameter int unsigned PC_W     = 32,
  parameter int unsigned QUANTUM  = 16,
  parameter int unsigned QW       = 5
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                instr_retire_i,
  input  logic [PC_W-1:0]     pc_curr_i,
  input  logic                end_proc_i,
  input  logic                yield_i,
  input  logic                dispatch_i,
  input  logic                proc_create_i,
  input  logic [PID_W-1:0]    create_pid_i,
  input  logic [PC_W-1:0]     create_pc_i,
  output logic [PID_W-1:0]    cur_pid_o,
  output logic                in_os_o,
  output logic                pc_load_o,
  output logic [PC_W-1:0]     pc_load_val_o,
  output logic                preempted_o,
  output logic [NUM_PROC-1:0] ready_mask_o
);

  typedef enum logic [1:0] {StOs, StLoad, StRun, StSave} state_e;

  state_e              state_q, state_d;
  logic [PID_W-1:0]    cur_pid_q, cur_pid_d;
  logic                in_os_q, in_os_d;
  logic                pc_load_q, pc_load_d;
  logic [PC_W-1:0]     pc_load_val_q, pc_load_val_d;
  logic                preempted_q, preempted_d;
  logic [NUM_PROC-1:0] ready_q, ready_d;
  logic [PC_W-1:0]     saved_pc_q [NUM_PROC];
  logic [PC_W-1:0]     saved_pc_d [NUM_PROC];
  logic [QW-1:0]       slice_q, slice_d;
  logic [PID_W-1:0]    rr_q, rr_d;

  logic [PID_W-1:0]    next_pid;
  logic                ready_nz;
  logic                create_ok;
  logic                go_save;
  logic                quantum_hit;

  // First ready user PID after rr, skipping PID 0 and wrapping NUM_PROC-1 -> 1.
  function automatic logic [PID_W-1:0] pick_next(input logic [PID_W-1:0]    rr,
                                                  input logic [NUM_PROC-1:0] rdy);
    logic [PID_W-1:0]    res;
    logic                found;
    logic [NUM_PROC-1:0] sh;
    int unsigned         idx;
    res   = rr;
    found = 1'b0;
    for (int unsigned k = 1; k < NUM_PROC; k++) begin
      // (rr - 1 + k) mod (NUM_PROC - 1), written to avoid unsigned underflow.
      idx = ((32'(rr) + NUM_PROC - 2 + k) % (NUM_PROC - 1)) + 1;
      sh  = rdy >> idx;
      if (!found && sh[0]) begin
        res   = PID_W'(idx);
        found = 1'b1;
      end
    end
    return res;
  endfunction

  assign next_pid  = pick_next(rr_q, ready_q);
  assign ready_nz  = |ready_q;
  assign create_ok = proc_create_i && (create_pid_i != '0) && (32'(create_pid_i) < NUM_PROC);

  // Next-state, context table and registered-output computation.
  always_comb begin
    state_d       = state_q;
    cur_pid_d     = cur_pid_q;
    in_os_d       = in_os_q;
    pc_load_d     = 1'b0;
    pc_load_val_d = pc_load_val_q;
    preempted_d   = 1'b0;
    ready_d       = ready_q;
    saved_pc_d    = saved_pc_q;
    slice_d       = slice_q;
    rr_d          = rr_q;
    go_save       = 1'b0;
    quantum_hit   = 1'b0;

    unique case (state_q)
      StOs: begin
        if (dispatch_i && ready_nz) begin
          saved_pc_d[0] = pc_curr_i;
          pc_load_d     = 1'b1;
          pc_load_val_d = saved_pc_q[next_pid];
          cur_pid_d     = next_pid;
          in_os_d       = 1'b0;
          state_d       = StLoad;
        end
      end
      StLoad: begin
        // cur_pid_q holds the PID selected on dispatch.
        rr_d    = cur_pid_q;
        slice_d = '0;
        state_d = StRun;
      end
      StRun: begin
        if (end_proc_i) begin
          ready_d[cur_pid_q] = 1'b0;
          go_save            = 1'b1;
        end else if (yield_i) begin
          saved_pc_d[cur_pid_q] = pc_curr_i;
          go_save               = 1'b1;
        end else if (instr_retire_i) begin
          if (slice_q == QW'(QUANTUM - 1)) begin
            saved_pc_d[cur_pid_q] = pc_curr_i;
            quantum_hit           = 1'b1;
            go_save               = 1'b1;
          end else begin
            slice_d = slice_q + 1'b1;
          end
        end
        if (go_save) begin
          pc_load_d     = 1'b1;
          pc_load_val_d = saved_pc_q[0];
          cur_pid_d     = '0;
          in_os_d       = 1'b1;
          preempted_d   = quantum_hit;
          state_d       = StSave;
        end
      end
      StSave: begin
        state_d = StOs;
      end
      default: begin
        state_d = StOs;
      end
    endcase

    // Create is applied last so it wins over a same-cycle save or end_proc.
    if (create_ok) begin
      saved_pc_d[create_pid_i] = create_pc_i;
      ready_d[create_pid_i]    = 1'b1;
    end
    ready_d[0] = 1'b0;
  end

  // State and context registers with asynchronous active-low reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= StOs;
      cur_pid_q     <= '0;
      in_os_q       <= 1'b1;
      pc_load_q     <= 1'b0;
      pc_load_val_q <= '0;
      preempted_q   <= 1'b0;
      ready_q       <= '0;
      slice_q       <= '0;
      rr_q          <= PID_W'(NUM_PROC - 1);
      for (int i = 0; i < NUM_PROC; i++) begin
        saved_pc_q[i] <= '0;
      end
    end else begin
      state_q       <= state_d;
      cur_pid_q     <= cur_pid_d;
      in_os_q       <= in_os_d;
      pc_load_q     <= pc_load_d;
      pc_load_val_q <= pc_load_val_d;
      preempted_q   <= preempted_d;
      ready_q       <= ready_d;
      slice_q       <= slice_d;
      rr_q          <= rr_d;
      saved_pc_q    <= saved_pc_d;
    end
  end

  assign cur_pid_o     = cur_pid_q;
  assign in_os_o       = in_os_q;
  assign pc_load_o     = pc_load_q;
  assign pc_load_val_o = pc_load_val_q;
  assign preempted_o   = preempted_q;
  assign ready_mask_o  = ready_q;

endmodule

// File: tb/tb_process_scheduler.sv
// Scoreboard bench for process_scheduler: a behavioural model pushes the
// expected pc_load events; a negedge monitor pops and compares them.
module tb_process_scheduler;

  localparam int NP = 4;
  localparam int QT = 4;

  logic        clk;
  logic        rst_n;
  logic        instr_retire, end_proc, yield, dispatch, proc_create;
  logic [31:0] pc_curr, create_pc;
  logic [1:0]  create_pid;
  logic [1:0]  cur_pid;
  logic        in_os, pc_load, preempted;
  logic [31:0] pc_load_val;
  logic [3:0]  ready_mask;

  process_scheduler #(
    .NUM_PROC(NP), .PID_W(2), .PC_W(32), .QUANTUM(QT), .QW(5)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .instr_retire_i(instr_retire), .pc_curr_i(pc_curr),
    .end_proc_i(end_proc), .yield_i(yield), .dispatch_i(dispatch),
    .proc_create_i(proc_create), .create_pid_i(create_pid), .create_pc_i(create_pc),
    .cur_pid_o(cur_pid), .in_os_o(in_os), .pc_load_o(pc_load),
    .pc_load_val_o(pc_load_val), .preempted_o(preempted), .ready_mask_o(ready_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [1:0]  pid;
    logic        os;
    logic        pre;
    logic [3:0]  rdy;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  bit   chk_en   = 0;

  // Behavioural model: scheduler mode, context table, ready set.
  localparam int MOs = 0, MLoad = 1, MRun = 2, MSave = 3;
  int          m_mode, m_run, m_rr, m_slice;
  logic [31:0] m_pc [NP];
  logic [3:0]  m_ready;

  task automatic model_reset();
    for (int i = 0; i < NP; i++) m_pc[i] = 32'h0;
    m_ready = 4'h0; m_rr = NP - 1; m_mode = MOs; m_slice = 0; m_run = 0;
  endtask

  function automatic int next_ready(input int from);
    int p;
    p = from;
    for (int k = 0; k < NP - 1; k++) begin
      p = (p >= NP - 1) ? 1 : p + 1;
      if (m_ready[p]) return p;
    end
    return from;
  endfunction

  // Apply the inputs the DUT just sampled; queue any expected pc_load event.
  task automatic model_step();
    exp_t e;
    bit   have;
    int   p;
    have = 0;
    e    = '0;
    case (m_mode)
      MOs: if (dispatch && m_ready != 4'h0) begin
        m_pc[0] = pc_curr;
        p = next_ready(m_rr);
        e.pc = m_pc[p]; e.pid = 2'(p); e.os = 1'b0; e.pre = 1'b0;
        m_run = p; m_mode = MLoad; have = 1;
      end
      MLoad: begin m_rr = m_run; m_slice = 0; m_mode = MRun; end
      MRun: begin
        if (end_proc) begin
          m_ready[m_run] = 1'b0; have = 1;
        end else if (yield) begin
          m_pc[m_run] = pc_curr; have = 1;
        end else if (instr_retire) begin
          m_slice++;
          if (m_slice == QT) begin m_pc[m_run] = pc_curr; e.pre = 1'b1; have = 1; end
        end
        if (have) begin e.pc = m_pc[0]; e.pid = 2'd0; e.os = 1'b1; m_mode = MSave; end
      end
      default: m_mode = MOs;
    endcase
    if (proc_create && create_pid != 2'd0) begin
      m_pc[create_pid] = create_pc; m_ready[create_pid] = 1'b1;
    end
    if (have) begin e.rdy = m_ready; exp_q.push_back(e); end
  endtask

  // Monitor: per-cycle context/ready check plus scoreboard of pc_load events.
  always @(negedge clk) begin
    if (chk_en) begin
      exp_t e;
      logic [1:0] mc;
      logic       mo;
      mc = (m_mode == MLoad || m_mode == MRun) ? 2'(m_run) : 2'd0;
      mo = (m_mode == MLoad || m_mode == MRun) ? 1'b0 : 1'b1;
      n_checks++;
      if ({cur_pid, in_os, ready_mask} !== {mc, mo, m_ready}) begin
        n_errors++;
        $display("FAIL ctx: pid/os/rdy got %0d/%0b/%b want %0d/%0b/%b at %0t",
                 cur_pid, in_os, ready_mask, mc, mo, m_ready, $time);
      end
      n_checks++;
      if (pc_load === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_errors++;
          $display("FAIL unexpected_pc_load: got pc_load=1 val=%h want pc_load=0 at %0t",
                   pc_load_val, $time);
        end else begin
          e = exp_q.pop_front();
          if ({pc_load_val, cur_pid, in_os, preempted, ready_mask} !== e) begin
            n_errors++;
            $display("FAIL load_event: got val=%h pid=%0d os=%0b pre=%0b rdy=%b want val=%h pid=%0d os=%0b pre=%0b rdy=%b at %0t",
                     pc_load_val, cur_pid, in_os, preempted, ready_mask,
                     e.pc, e.pid, e.os, e.pre, e.rdy, $time);
          end
        end
      end else begin
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          n_errors++;
          $display("FAIL missing_pc_load: got pc_load=%b want 1 (val=%h) at %0t",
                   pc_load, e.pc, $time);
        end else if (preempted !== 1'b0) begin
          n_errors++;
          $display("FAIL stray_preempted: got %b want 0 at %0t", preempted, $time);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_pulses();
    instr_retire = 0; end_proc = 0; yield = 0; dispatch = 0; proc_create = 0;
  endtask

  // One clock: the edge samples the current inputs, then the model follows.
  task automatic tick();
    @(posedge clk);
    #1;
    model_step();
    clear_pulses();
  endtask

  task automatic do_reset();
    chk_en = 0;
    rst_n  = 1'b0;
    clear_pulses();
    #1;
    check("rst_cur_pid", 32'(cur_pid), 32'd0);
    check("rst_in_os", 32'(in_os), 32'd1);
    check("rst_pc_load", 32'(pc_load), 32'd0);
    check("rst_pc_load_val", pc_load_val, 32'h0);
    check("rst_preempted", 32'(preempted), 32'd0);
    check("rst_ready_mask", 32'(ready_mask), 32'd0);
    exp_q.delete();
    model_reset();
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1 chk_en = 1;
  endtask

  task automatic create(input logic [1:0] pid, input logic [31:0] pc);
    proc_create = 1; create_pid = pid; create_pc = pc;
    tick();
  endtask

  task automatic dispatch_expect(input int pid);
    dispatch = 1;
    tick();
    check("disp_pc_load", 32'(pc_load), 32'd1);
    check("disp_pid", 32'(cur_pid), 32'(pid));
  endtask

  // RUN, then yield, then back in OS.
  task automatic yield_out();
    tick();
    yield = 1;
    tick();
    check("yield_preempted", 32'(preempted), 32'd0);
    tick();
  endtask

  int exp_order [4] = '{1, 2, 3, 1};

  initial begin
    rst_n = 1'b1;
    clear_pulses();
    pc_curr = 32'h100; create_pid = 2'd0; create_pc = 32'h0;
    #2;
    do_reset();

    // Quantum expiry path.
    create(2'd1, 32'h40);
    dispatch_expect(1);
    check("q_load_val", pc_load_val, 32'h40);
    check("q_in_os", 32'(in_os), 32'd0);
    tick();
    for (int i = 0; i < QT; i++) begin
      if (i == QT - 1) pc_curr = 32'h50;
      instr_retire = 1;
      tick();
    end
    check("q_preempted", 32'(preempted), 32'd1);
    check("q_save_val", pc_load_val, 32'h100);
    check("q_save_pid", 32'(cur_pid), 32'd0);
    pc_curr = 32'h100;
    tick();
    dispatch_expect(1);
    check("q_reload_val", pc_load_val, 32'h50);
    tick();
    yield = 1;
    tick();
    tick();

    // Round-robin order over three ready processes.
    do_reset();
    create(2'd1, 32'h10);
    create(2'd2, 32'h20);
    create(2'd3, 32'h30);
    for (int i = 0; i < 4; i++) begin
      dispatch_expect(exp_order[i]);
      pc_curr = 32'h200 + 32'(i);
      yield_out();
      pc_curr = 32'h100;
    end

    // end_proc beats yield; PID 2 is then skipped.
    dispatch_expect(2);
    tick();
    end_proc = 1; yield = 1;
    tick();
    check("end_preempted", 32'(preempted), 32'd0);
    check("end_ready_mask", 32'(ready_mask), 32'b1010);
    tick();
    dispatch_expect(3);
    yield_out();
    dispatch_expect(1);
    yield_out();
    dispatch_expect(3);
    yield_out();

    // Dispatch with nothing ready is ignored.
    do_reset();
    dispatch = 1;
    tick();
    check("empty_pc_load", 32'(pc_load), 32'd0);
    check("empty_pid", 32'(cur_pid), 32'd0);
    tick();

    // Reset asserted during LOAD, then a create on PID 0.
    create(2'd2, 32'h80);
    dispatch_expect(2);
    #1;
    do_reset();
    create(2'd0, 32'h90);
    check("pid0_ready_mask", 32'(ready_mask), 32'd0);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      pc_curr      = {$urandom_range(0, 32'h3fff), 2'b00};
      dispatch     = ($urandom_range(0, 99) < 30);
      instr_retire = ($urandom_range(0, 99) < 50);
      yield        = ($urandom_range(0, 99) < 5);
      end_proc     = ($urandom_range(0, 99) < 3);
      proc_create  = ($urandom_range(0, 99) < 15);
      create_pid   = 2'($urandom_range(0, 3));
      create_pc    = {$urandom_range(0, 32'h3fff), 2'b00};
      tick();
    end
    tick();
    tick();
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
